// File: rtl/exec_if.sv
// Execute-stage bus: issue side from the control unit plus the write-back
// side toward the register bank. Master = control/bank, slave = exec_stage.
interface exec_if #(
  parameter int DW = 32,
  parameter int AW = 4
);
  logic          start;
  logic [3:0]    op;
  logic [AW-1:0] rd_in;
  logic [DW-1:0] rs1_data;
  logic [DW-1:0] rs2_data;
  logic          flush;
  logic          ready;
  logic          busy;
  logic [DW-1:0] write_data;
  logic [AW-1:0] rd_addr;
  logic          reg_write;
  logic          zero;
  logic          carry;
  logic          illegal;

  modport master (
    output start, op, rd_in, rs1_data, rs2_data, flush,
    input  ready, busy, write_data, rd_addr, reg_write, zero, carry, illegal
  );

  modport slave (
    input  start, op, rd_in, rs1_data, rs2_data, flush,
    output ready, busy, write_data, rd_addr, reg_write, zero, carry, illegal
  );
endinterface

// File: rtl/exec_stage.sv
// Execute stage: single-cycle ALU plus optional iterative shift-add multiplier.
// Results return to the register bank as a one-cycle reg_write strobe.
// Build option: define EXEC_MUL_EN to include the multiplier; otherwise op 12
// is reported as illegal and busy stays low.
module exec_stage #(
  parameter int DW      = 32,
  parameter int AW      = 4,
  parameter int MUL_CYC = 32
) (
  input logic  clk,
  input logic  rst_n,   // active-high asynchronous reset
  exec_if.slave bus
);

  localparam int SW = $clog2(DW);

  if (MUL_CYC != DW) begin : g_cfg_check
    $error("exec_stage: MUL_CYC must equal DW");
  end

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_AND = 4'd2,  OP_OR  = 4'd3,
    OP_XOR = 4'd4,  OP_NOT = 4'd5,  OP_SLA = 4'd6,  OP_SRA = 4'd7,
    OP_SRL = 4'd8,  OP_INC = 4'd9,  OP_DEC = 4'd10, OP_SLT = 4'd11,
    OP_MUL = 4'd12
  } op_e;

  typedef enum logic {S_IDLE, S_MUL} state_e;

  state_e        state, state_next;
  logic          accept;
  logic          issue_mul;
  logic          mul_done;
  logic [DW:0]   sum;
  logic [DW-1:0] alu_res;
  logic          alu_cy;
  logic          alu_legal;
  logic [SW-1:0] sh;

  assign accept = bus.start && (state == S_IDLE) && !bus.flush;
  assign sh     = bus.rs2_data[SW-1:0];

`ifdef EXEC_MUL_EN
  localparam int CW = $clog2(MUL_CYC);
  localparam logic [CW-1:0] LAST = CW'(MUL_CYC - 1);

  logic [DW-1:0] mcand, mplier, acc, acc_next;
  logic [CW-1:0] cnt;
  logic [AW-1:0] mul_rd;

  assign issue_mul = accept && (bus.op == OP_MUL);
  assign mul_done  = (state == S_MUL) && !bus.flush && (cnt == LAST);
  assign acc_next  = acc + (mplier[0] ? mcand : '0);

  // Shift-add iteration: multiplicand walks left, multiplier walks right.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      mul_rd <= '0;
    end else if (issue_mul) begin
      mcand  <= bus.rs1_data;
      mplier <= bus.rs2_data;
      acc    <= '0;
      cnt    <= '0;
      mul_rd <= bus.rd_in;
    end else if (state == S_MUL && !bus.flush) begin
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      acc    <= acc_next;
      cnt    <= cnt + 1'b1;
    end
  end
`else
  assign issue_mul = 1'b0;
  assign mul_done  = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (issue_mul) state_next = S_MUL;
      S_MUL: begin
`ifdef EXEC_MUL_EN
        if (bus.flush || cnt == LAST) state_next = S_IDLE;
`else
        state_next = S_IDLE;
`endif
      end
      default: state_next = S_IDLE;
    endcase
  end

  // FSM-derived handshake outputs.
  always_comb begin
    bus.ready = (state == S_IDLE);
    bus.busy  = (state == S_MUL);
  end

  // Single-cycle ALU; carry is bit DW of a (DW+1)-bit sum.
  always_comb begin
    sum       = '0;
    alu_res   = '0;
    alu_cy    = 1'b0;
    alu_legal = 1'b1;
    case (bus.op)
      OP_ADD: begin
        sum     = {1'b0, bus.rs1_data} + {1'b0, bus.rs2_data};
        alu_res = sum[DW-1:0];
        alu_cy  = sum[DW];
      end
      OP_SUB: begin
        sum     = {1'b0, bus.rs1_data} + {1'b0, ~bus.rs2_data} + (DW+1)'(1);
        alu_res = sum[DW-1:0];
        alu_cy  = sum[DW];
      end
      OP_AND: alu_res = bus.rs1_data & bus.rs2_data;
      OP_OR:  alu_res = bus.rs1_data | bus.rs2_data;
      OP_XOR: alu_res = bus.rs1_data ^ bus.rs2_data;
      OP_NOT: alu_res = ~bus.rs1_data;
      OP_SLA: alu_res = bus.rs1_data << sh;
      OP_SRA: alu_res = $unsigned($signed(bus.rs1_data) >>> sh);
      OP_SRL: alu_res = bus.rs1_data >> sh;
      OP_INC: begin
        sum     = {1'b0, bus.rs1_data} + (DW+1)'(1);
        alu_res = sum[DW-1:0];
        alu_cy  = sum[DW];
      end
      OP_DEC: begin
        sum     = {1'b0, bus.rs1_data} + {1'b0, {DW{1'b1}}};
        alu_res = sum[DW-1:0];
        alu_cy  = sum[DW];
      end
      OP_SLT: alu_res = {{(DW-1){1'b0}}, ($signed(bus.rs1_data) < $signed(bus.rs2_data))};
`ifdef EXEC_MUL_EN
      OP_MUL: alu_legal = 1'b1;
`endif
      default: alu_legal = 1'b0;
    endcase
  end

  // Registered write-back strobes; everything returns to 0 unless an op completes.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      bus.reg_write  <= 1'b0;
      bus.write_data <= '0;
      bus.rd_addr    <= '0;
      bus.zero       <= 1'b0;
      bus.carry      <= 1'b0;
      bus.illegal    <= 1'b0;
    end else begin
      bus.reg_write  <= 1'b0;
      bus.write_data <= '0;
      bus.rd_addr    <= '0;
      bus.zero       <= 1'b0;
      bus.carry      <= 1'b0;
      bus.illegal    <= 1'b0;
      if (accept && !issue_mul) begin
        if (alu_legal) begin
          bus.reg_write  <= 1'b1;
          bus.write_data <= alu_res;
          bus.rd_addr    <= bus.rd_in;
          bus.zero       <= (alu_res == '0);
          bus.carry      <= alu_cy;
        end else begin
          bus.illegal    <= 1'b1;
        end
      end
`ifdef EXEC_MUL_EN
      else if (mul_done) begin
        bus.reg_write  <= 1'b1;
        bus.write_data <= acc_next;
        bus.rd_addr    <= mul_rd;
        bus.zero       <= (acc_next == '0);
      end
`else
      else if (mul_done) begin
        bus.reg_write  <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_exec_stage.sv
// Scoreboard bench for exec_stage: expectations are queued at issue time and
// popped when the stage reports reg_write or illegal.
module tb_exec_stage;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  rd;
    logic        rw;
    logic        z;
    logic        c;
    logic        ill;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];

  exec_if #(.DW(32), .AW(4)) bus ();

  exec_stage #(.DW(32), .AW(4), .MUL_CYC(32)) dut (
    .clk   (clk),
    .rst_n (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [3:0] rd);
    exp_t        e;
    logic [63:0] w;
    int unsigned sh;
    sh = int'(b[4:0]);
    e = '0;
    e.rw = 1'b1;
    e.rd = rd;
    case (op)
      4'd0:  begin w = 64'(a) + 64'(b); e.data = w[31:0]; e.c = w[32]; end
      4'd1:  begin e.data = a - b; e.c = (a >= b); end
      4'd2:  e.data = a & b;
      4'd3:  e.data = a | b;
      4'd4:  e.data = a ^ b;
      4'd5:  e.data = ~a;
      4'd6:  e.data = a << sh;
      4'd7:  begin w = {{32{a[31]}}, a} >> sh; e.data = w[31:0]; end
      4'd8:  e.data = a >> sh;
      4'd9:  begin e.data = a + 32'd1; e.c = (a == 32'hFFFF_FFFF); end
      4'd10: begin e.data = a - 32'd1; e.c = (a != 32'd0); end
      4'd11: e.data = (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, (a < b)};
`ifdef EXEC_MUL_EN
      4'd12: begin w = 64'(a) * 64'(b); e.data = w[31:0]; end
`endif
      default: begin e = '0; e.ill = 1'b1; end
    endcase
    if (e.rw) e.z = (e.data == 32'd0);
    return e;
  endfunction

  // Drive one start; push the expected outcome only if the op should complete.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] rd, input bit push);
    bus.op = op; bus.rs1_data = a; bus.rs2_data = b; bus.rd_in = rd; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    if (push) sb.push_back(model(op, a, b, rd));
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) begin
      @(negedge clk); #1;
    end
    check_eq("drain", sb.size(), 0);
  endtask

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.reg_write || bus.illegal) begin
        if (sb.size() == 0) begin
          check_eq("unexpected_out", {30'd0, bus.reg_write, bus.illegal}, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check_eq("reg_write", 32'(bus.reg_write), 32'(e.rw));
          check_eq("illegal",   32'(bus.illegal),   32'(e.ill));
          check_eq("zero",      32'(bus.zero),      32'(e.z));
          check_eq("carry",     32'(bus.carry),     32'(e.c));
          if (e.rw) begin
            check_eq("write_data", bus.write_data, e.data);
            check_eq("rd_addr",    32'(bus.rd_addr), 32'(e.rd));
          end
        end
      end else begin
        check_eq("idle_flags", {30'd0, bus.zero, bus.carry}, 32'd0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] specials [6];
    logic [3:0]  rop;
    logic [31:0] ra, rb;
    specials = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_001F};

    bus.start = 1'b0; bus.op = '0; bus.rd_in = '0; bus.rs1_data = '0;
    bus.rs2_data = '0; bus.flush = 1'b0;

    repeat (2) @(posedge clk); #1;
    check_eq("rst_ready",     32'(bus.ready),     32'd1);
    check_eq("rst_busy",      32'(bus.busy),      32'd0);
    check_eq("rst_reg_write", 32'(bus.reg_write), 32'd0);
    check_eq("rst_illegal",   32'(bus.illegal),   32'd0);
    check_eq("rst_data",      bus.write_data,     32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed single-cycle ops, issued back to back.
    issue(4'd0,  32'd1,         32'd22,        4'd1, 1);
    issue(4'd1,  32'd22,        32'd22,        4'd2, 1);
    issue(4'd0,  32'hFFFF_FFFF, 32'd1,         4'd3, 1);
    issue(4'd1,  32'd5,         32'd7,         4'd4, 1);
    issue(4'd7,  32'h8000_0010, 32'd4,         4'd5, 1);
    issue(4'd8,  32'h8000_0010, 32'd4,         4'd6, 1);
    issue(4'd6,  32'h0000_0003, 32'h0000_0021, 4'd7, 1);
    issue(4'd11, 32'hFFFF_FFFE, 32'd1,         4'd8, 1);
    issue(4'd11, 32'd3,         32'hFFFF_FFFF, 4'd9, 1);
    issue(4'd9,  32'hFFFF_FFFF, 32'd0,         4'd10, 1);
    issue(4'd10, 32'd0,         32'd0,         4'd11, 1);
    issue(4'd5,  32'hFFFF_FFFF, 32'd0,         4'd0, 1);
    issue(4'd14, 32'd1,         32'd2,         4'd12, 1);
    issue(4'd13, 32'd1,         32'd2,         4'd12, 1);
    issue(4'd15, 32'd1,         32'd2,         4'd12, 1);
    wait_drain(5);

    // Random single-cycle traffic.
    for (int i = 0; i < 40; i++) begin
      rop = 4'($urandom_range(0, 15));
`ifdef EXEC_MUL_EN
      if (rop == 4'd12) rop = 4'd4;
`endif
      ra = ($urandom_range(0, 2) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
      rb = ($urandom_range(0, 2) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
      issue(rop, ra, rb, 4'($urandom_range(0, 15)), 1);
    end
    wait_drain(5);

    // flush together with start drops the start; flush alone in IDLE is harmless.
    bus.flush = 1'b1;
    issue(4'd0, 32'd5, 32'd6, 4'd3, 0);
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check_eq("flush_idle_ready", 32'(bus.ready), 32'd1);
    issue(4'd0, 32'd5, 32'd6, 4'd3, 1);
    wait_drain(5);

`ifdef EXEC_MUL_EN
    // MUL 349*56 with an ignored start mid-run.
    issue(4'd12, 32'd349, 32'd56, 4'd6, 1);
    check_eq("mul_ready_e0", 32'(bus.ready), 32'd0);
    for (int k = 1; k <= 31; k++) begin
      if (k == 10) begin
        bus.op = 4'd0; bus.rs1_data = 32'd9; bus.rs2_data = 32'd9; bus.start = 1'b1;
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
      check_eq("mul_busy", 32'(bus.busy), 32'd1);
    end
    @(posedge clk); #1;
    check_eq("mul_done_busy",  32'(bus.busy),      32'd0);
    check_eq("mul_done_ready", 32'(bus.ready),     32'd1);
    check_eq("mul_done_rw",    32'(bus.reg_write), 32'd1);
    check_eq("mul_done_data",  bus.write_data,     32'd19544);
    issue(4'd0, 32'd2, 32'd3, 4'd1, 1);
    wait_drain(5);

    // Random-operand MUL.
    ra = $urandom; rb = $urandom;
    issue(4'd12, ra, rb, 4'd9, 1);
    wait_drain(40);

    // Flush at iteration 5.
    issue(4'd12, 32'd7, 32'd9, 4'd2, 0);
    repeat (4) begin @(posedge clk); #1; end
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check_eq("flush_ready", 32'(bus.ready),     32'd1);
    check_eq("flush_busy",  32'(bus.busy),      32'd0);
    check_eq("flush_rw",    32'(bus.reg_write), 32'd0);
    issue(4'd0, 32'd40, 32'd2, 4'd5, 1);
    wait_drain(5);

    // Reset at iteration 20.
    issue(4'd12, 32'd11, 32'd13, 4'd4, 0);
    repeat (19) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    check_eq("midrst_ready", 32'(bus.ready),     32'd1);
    check_eq("midrst_busy",  32'(bus.busy),      32'd0);
    check_eq("midrst_rw",    32'(bus.reg_write), 32'd0);
    check_eq("midrst_data",  bus.write_data,     32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check_eq("postrst_ready", 32'(bus.ready), 32'd1);
`else
    // Without the multiplier, op 12 is illegal and never busies the stage.
    issue(4'd12, 32'd349, 32'd56, 4'd6, 1);
    check_eq("nomul_busy",  32'(bus.busy),  32'd0);
    check_eq("nomul_ready", 32'(bus.ready), 32'd1);
    issue(4'd0, 32'd2, 32'd3, 4'd1, 1);
    wait_drain(5);
`endif

    wait_drain(5);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
